pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline stall/flush/redirect controller for the yadan core. Takes per-stage stall

---
 rtl/pipe_hazard_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Bundle of the hazard controller's request and response signals.
//   master : request side (stage stall requests, branch/trap redirects);
//            observes the stall/flush vectors and the PC redirect.
//   slave  : the hazard controller itself.
// Handshake: there is no valid/ready pair. redirect_o is a load strobe
// with no back-pressure. The PC consumes it in the first cycle that
// stalled_o[0]=0. Until then the controller keeps re-presenting it,
// with redirect_pend_o=1 from the second cycle on. stalled_o and flush_o
// are level signals that the pipeline registers sample every clock.
interface pipe_hazard_if #(
    parameter int NSTAGE = 6,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    logic [NSTAGE-1:0] stall_req_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_addr_i;
    logic              trap_i;
    logic [ADDR_W-1:0] trap_addr_i;
    logic              redirect_o;
    logic [ADDR_W-1:0] redirect_addr_o;
    logic              redirect_pend_o;
    logic [NSTAGE-1:0] stalled_o;
    logic [NSTAGE-1:0] flush_o;
    logic [CNT_W-1:0]  stall_cycles_o;
    logic              stall_timeout_o;

    modport master (
        output stall_req_i, branch_flag_i, branch_addr_i, trap_i, trap_addr_i,
        input  redirect_o, redirect_addr_o, redirect_pend_o, stalled_o, flush_o,
               stall_cycles_o, stall_timeout_o
    );

    modport slave (
        input  stall_req_i, branch_flag_i, branch_addr_i, trap_i, trap_addr_i,
        output redirect_o, redirect_addr_o, redirect_pend_o, stalled_o, flush_o,
               stall_cycles_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/redirect controller for the yadan core.
// Stage stall requests and branch/trap redirects arrive on the bus.
// The controller returns per-stage stall and flush vectors and a PC
// redirect, all combinationally. The only registered state is:
//   - the pending redirect (pend_q/pend_addr_q), held while the PC is frozen;
//   - the consecutive-stall counter;
//   - the sticky watchdog flag.
// The pending bit is the controller's only control state. It is visible
// as redirect_pend_o.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset. Also forces every output to 0
//        while it is high.
//   bus  pipe_hazard_if.slave (see the interface for the signal list)
module pipe_hazard_ctrl #(
    parameter int                NSTAGE     = 6,
    parameter int                ADDR_W     = 32,
    parameter int                BR_STAGE   = 3,
    parameter logic [NSTAGE-1:0] BR_MASK    = 6'b001100,
    parameter int                CNT_W      = 8,
    parameter logic [CNT_W-1:0]  WDOG_LIMIT = 8'd200
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_if.slave     bus
);

    function automatic logic [NSTAGE-1:0] range_mask(input int lo, input int hi);
        logic [NSTAGE-1:0] m;
        m = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (k >= lo && k <= hi) m[k] = 1'b1;
        end
        return m;
    endfunction

    // A trap squashes every in-flight stage except WB. A branch squashes
    // only the stages younger than the resolving stage.
    localparam logic [NSTAGE-1:0] TRAP_FLUSH = range_mask(1, NSTAGE-2);
    localparam logic [NSTAGE-1:0] BR_FLUSH   = range_mask(1, BR_STAGE-1);
    localparam logic [NSTAGE-1:0] DOWN_MASK  = range_mask(BR_STAGE+1, NSTAGE-1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    logic              pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              timeout_q;

    logic              br_live;
    logic              br_acc;
    logic [NSTAGE-1:0] req_eff;
    logic [NSTAGE-1:0] stalled;
    logic [NSTAGE-1:0] flush;
    logic              redir;
    logic [ADDR_W-1:0] redir_addr;
    logic              acc;

    always_comb begin
        // While a redirect is pending, anything in the branch stage is on
        // the wrong path, so its branch flag is ignored.
        br_live = bus.branch_flag_i & ~pend_q;
        req_eff = bus.stall_req_i & ~(br_live ? BR_MASK : '0);

        // Stage k holds if it or any later stage holds. This yields the
        // contiguous low-order mask up to the highest requesting stage.
        // Where flush_o is also set, the pipeline register clears rather
        // than holds.
        acc     = 1'b0;
        stalled = '0;
        for (int k = NSTAGE-1; k >= 0; k--) begin
            acc        = acc | req_eff[k];
            stalled[k] = acc;
        end

        // A stall downstream of the branch stage keeps the branch in
        // place. It is then re-presented next cycle.
        br_acc = br_live & ~|(bus.stall_req_i & DOWN_MASK);

        redir      = 1'b0;
        redir_addr = '0;
        flush      = '0;
        if (bus.trap_i) begin
            redir      = 1'b1;
            redir_addr = bus.trap_addr_i;
            flush      = TRAP_FLUSH;
        end else if (br_acc) begin
            redir      = 1'b1;
            redir_addr = bus.branch_addr_i;
            flush      = BR_FLUSH;
        end else if (pend_q) begin
            redir      = 1'b1;
            redir_addr = pend_addr_q;
            flush      = BR_FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            // The PC loads in any cycle it is not held. Otherwise the
            // current redirect, which may be a newer trap, is kept.
            if (redir && stalled[0]) begin
                pend_q      <= 1'b1;
                pend_addr_q <= redir_addr;
            end else if (!stalled[0]) begin
                pend_q      <= 1'b0;
            end

            if (stalled != '0) begin
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end

            if (cnt_q == WDOG_LIMIT) timeout_q <= 1'b1;
        end
    end

    assign bus.redirect_o      = redir & ~rst;
    assign bus.redirect_addr_o = rst ? '0 : redir_addr;
    assign bus.redirect_pend_o = pend_q & ~rst;
    assign bus.stalled_o       = rst ? '0 : stalled;
    assign bus.flush_o         = rst ? '0 : flush;
    assign bus.stall_cycles_o  = rst ? '0 : cnt_q;
    assign bus.stall_timeout_o = timeout_q & ~rst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int NSTAGE = 6;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;
    localparam int W      = 1 + ADDR_W + 1 + NSTAGE + NSTAGE + CNT_W + 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_if #(.NSTAGE(NSTAGE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard ----------------
    // Expected word layout: {redirect, addr, pend, stalled, flush, cycles, timeout}
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         vec_valid;
    int           checks;
    int           errors;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic [NSTAGE-1:0] stall,
                         input logic br, input logic [ADDR_W-1:0] baddr,
                         input logic tr, input logic [ADDR_W-1:0] taddr);
        @(posedge clk);
        #1;
        vec_valid         = 1'b0;
        rst               = r;
        bus.stall_req_i   = stall;
        bus.branch_flag_i = br;
        bus.branch_addr_i = baddr;
        bus.trap_i        = tr;
        bus.trap_addr_i   = taddr;
    endtask

    task automatic exp_out(input logic redir, input logic [ADDR_W-1:0] raddr,
                           input logic pend, input logic [NSTAGE-1:0] stalled,
                           input logic [NSTAGE-1:0] flush, input logic [CNT_W-1:0] cyc,
                           input logic tmo, input string name);
        exp_q.push_back({redir, raddr, pend, stalled, flush, cyc, tmo});
        name_q.push_back(name);
        vec_valid = 1'b1;
    endtask

    task automatic idle_n(input int n, input logic [NSTAGE-1:0] stall);
        for (int i = 0; i < n; i++) drive(1'b0, stall, 1'b0, '0, 1'b0, '0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (vec_valid) begin
            logic [W-1:0] act;
            logic [W-1:0] exp_w;
            string        nm;
            act = {bus.redirect_o, bus.redirect_addr_o, bus.redirect_pend_o, bus.stalled_o,
                   bus.flush_o, bus.stall_cycles_o, bus.stall_timeout_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow got %h required <queued entry>", act);
            end else begin
                exp_w = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act !== exp_w) begin
                    errors++;
                    $display("FAIL %s got %h required %h", nm, act, exp_w);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        vec_valid = 1'b0;
        rst       = 1'b1;
        bus.stall_req_i   = '0;
        bus.branch_flag_i = 1'b0;
        bus.branch_addr_i = '0;
        bus.trap_i        = 1'b0;
        bus.trap_addr_i   = '0;

        // Reset forces outputs low even with every request active.
        drive(1, 6'h3F, 1, 32'h80, 1, 32'h4);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd0, 0, "reset_force");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd0, 0, "idle");

        // T1: stall mask up to the highest requester
        drive(0, 6'b010000, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b011111, 6'h00, 8'd0, 0, "t1_mem");
        drive(0, 6'b000100, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b000111, 6'h00, 8'd1, 0, "t1_id");
        drive(0, 6'b111111, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b111111, 6'h00, 8'd2, 0, "t1_all");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd3, 0, "t1_release");

        // T2: taken branch masks ID/EX stall requests
        drive(0, 6'b001100, 1, 32'h80, 0, 0);
        exp_out(1, 32'h80, 0, 6'h00, 6'b000110, 8'd0, 0, "t2_branch");
        // Branch blocked by a MEM stall is not accepted.
        drive(0, 6'b010000, 1, 32'h90, 0, 0);
        exp_out(0, 32'h0, 0, 6'b011111, 6'h00, 8'd0, 0, "t2_blocked");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd1, 0, "t2_idle");

        // T3: redirect held while IF/PC stalled
        drive(0, 6'b000010, 1, 32'h100, 0, 0);
        exp_out(1, 32'h100, 0, 6'b000011, 6'b000110, 8'd0, 0, "t3_c1");
        drive(0, 6'b000010, 1, 32'h200, 0, 0);   // wrong-path branch, ignored
        exp_out(1, 32'h100, 1, 6'b000011, 6'b000110, 8'd1, 0, "t3_c2");
        drive(0, 6'b000010, 0, 0, 0, 0);
        exp_out(1, 32'h100, 1, 6'b000011, 6'b000110, 8'd2, 0, "t3_c3");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(1, 32'h100, 1, 6'h00, 6'b000110, 8'd3, 0, "t3_consume");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd0, 0, "t3_after");

        // T4: trap overrides a pending branch redirect
        drive(0, 6'b000001, 1, 32'h100, 0, 0);
        exp_out(1, 32'h100, 0, 6'b000001, 6'b000110, 8'd0, 0, "t4_branch");
        drive(0, 6'b000001, 0, 0, 1, 32'h4);
        exp_out(1, 32'h4, 1, 6'b000001, 6'b011110, 8'd1, 0, "t4_trap");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(1, 32'h4, 1, 6'h00, 6'b000110, 8'd2, 0, "t4_pend_trap");
        // Trap and branch in the same cycle: trap wins.
        drive(0, 6'h00, 1, 32'h300, 1, 32'h8);
        exp_out(1, 32'h8, 0, 6'h00, 6'b011110, 8'd0, 0, "t4_trap_vs_br");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd0, 0, "t4_idle");

        // T5: watchdog
        drive(0, 6'b010000, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b011111, 6'h00, 8'd0, 0, "t5_start");
        idle_n(198, 6'b010000);
        drive(0, 6'b010000, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b011111, 6'h00, 8'd199, 0, "t5_199");
        drive(0, 6'b010000, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b011111, 6'h00, 8'd200, 0, "t5_200");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd201, 1, "t5_timeout");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd0, 1, "t5_sticky");
        // Counter saturation
        drive(0, 6'b010000, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b011111, 6'h00, 8'd0, 1, "t5_restart");
        idle_n(254, 6'b010000);
        drive(0, 6'b010000, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b011111, 6'h00, 8'd255, 1, "t5_max");
        drive(0, 6'b010000, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'b011111, 6'h00, 8'd255, 1, "t5_saturate");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd255, 1, "t5_release");

        // T6: reset during a pending redirect
        drive(0, 6'b000010, 1, 32'h100, 0, 0);
        exp_out(1, 32'h100, 0, 6'b000011, 6'b000110, 8'd0, 1, "t6_branch");
        drive(0, 6'b000010, 0, 0, 0, 0);
        exp_out(1, 32'h100, 1, 6'b000011, 6'b000110, 8'd1, 1, "t6_pend");
        drive(1, 6'b000010, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd0, 0, "t6_in_reset");
        drive(0, 6'h00, 0, 0, 0, 0);
        exp_out(0, 32'h0, 0, 6'h00, 6'h00, 8'd0, 0, "t6_after_reset");

        drive(0, 6'h00, 0, 0, 0, 0);

        // Drain: every queued expectation must have been consumed.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d left required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
